// File: rtl/park_pkg.sv
// Shared types and width helpers for the car-park exit controller.
package park_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        VERIFY = 3'd2,
        OPEN   = 3'd3,
        REJECT = 3'd4
    } state_t;

    localparam logic [3:0] PASSWORD_DEF = 4'b1010;

    function automatic int idx_w(input int slots);
        return $clog2(slots);
    endfunction

    function automatic int cnt_w(input int slots);
        return $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/park_exit_if.sv
// Exit-controller signal bundle: entry admits, exit request, gate status.
interface park_exit_if #(
    parameter int N     = 4,
    parameter int SLOTS = 16
);
    import park_pkg::*;

    localparam int IW = idx_w(SLOTS);
    localparam int CW = cnt_w(SLOTS);

    logic          entry_vld;
    logic [N-1:0]  entry_vn;
    logic          start;
    logic [N-1:0]  vn;
    logic [N-1:0]  pswd;
    logic          gate;
    logic [IW-1:0] slot;
    logic          err;
    logic          full;
    logic [CW-1:0] count;

    modport master (
        output entry_vld, entry_vn, start, vn, pswd,
        input  gate, slot, err, full, count
    );

    modport slave (
        input  entry_vld, entry_vn, start, vn, pswd,
        output gate, slot, err, full, count
    );

endinterface

// File: rtl/park_table.sv
// Occupancy table: lowest-free-slot write with duplicate rejection, indexed
// read for the search, single-slot clear for departures.
module park_table
    import park_pkg::*;
#(
    parameter int  N     = 4,
    parameter int  SLOTS = 16,
    localparam int IW    = idx_w(SLOTS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_i,
    input  logic [N-1:0]  wr_dat_i,
    output logic          wr_acc_o,
    input  logic          clr_i,
    input  logic [IW-1:0] clr_idx_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [N-1:0]  rd_dat_o,
    output logic          rd_vld_o,
    output logic          full_o
);

    logic [N-1:0]     tbl_q [SLOTS];
    logic [SLOTS-1:0] vld_q;
    logic [IW-1:0]    free_idx;
    logic             dup;

    // Descending scan so the last assignment wins with the lowest free index.
    always_comb begin
        free_idx = '0;
        dup      = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!vld_q[i]) free_idx = IW'(i);
        end
        for (int j = 0; j < SLOTS; j++) begin
            if (vld_q[j] && (tbl_q[j] == wr_dat_i)) dup = 1'b1;
        end
    end

    assign full_o   = &vld_q;
    assign wr_acc_o = wr_i && !full_o && !dup;
    assign rd_dat_o = tbl_q[rd_idx_i];
    assign rd_vld_o = vld_q[rd_idx_i];

    // A slot cleared this edge still reads valid to the free search, so it
    // cannot be handed out again until the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            if (clr_i)    vld_q[clr_idx_i] <= 1'b0;
            if (wr_acc_o) vld_q[free_idx]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc_o) tbl_q[free_idx] <= wr_dat_i;
    end

endmodule

// File: rtl/park_exit.sv
// Exit controller: search the occupancy table for the departing vehicle,
// check the password, free its slot and hold the gate open for OPEN_CYC cycles.
module park_exit
    import park_pkg::*;
#(
    parameter int          N        = 4,
    parameter int          SLOTS    = 16,
    parameter logic [N-1:0] PASSWORD = N'(PASSWORD_DEF),
    parameter int          OPEN_CYC = 4,
    parameter int          TIMEOUT  = 8
) (
    input logic         clk,
    input logic         rst_n,
    park_exit_if.slave  bus
);

    localparam int IW = idx_w(SLOTS);
    localparam int CW = cnt_w(SLOTS);
    localparam int TW = $clog2(TIMEOUT + OPEN_CYC + 1);

    state_t        state_q, state_d;
    logic [IW-1:0] index_q, index_d;
    logic [IW-1:0] slot_q, slot_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] count_q;
    logic          start_q;
    logic          gate_q, gate_d;
    logic          err_q, err_d;
    logic          clr;
    logic          wr_acc;
    logic          rd_vld;
    logic [N-1:0]  rd_dat;
    logic          hit;
    logic          full;

    park_table #(
        .N     (N),
        .SLOTS (SLOTS)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (bus.entry_vld),
        .wr_dat_i  (bus.entry_vn),
        .wr_acc_o  (wr_acc),
        .clr_i     (clr),
        .clr_idx_i (slot_q),
        .rd_idx_i  (index_q),
        .rd_dat_o  (rd_dat),
        .rd_vld_o  (rd_vld),
        .full_o    (full)
    );

    assign hit = rd_vld && (rd_dat == bus.vn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= '0;
            slot_q  <= '0;
            timer_q <= '0;
            start_q <= 1'b0;
            gate_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            slot_q  <= slot_d;
            timer_q <= timer_d;
            start_q <= bus.start;
            gate_q  <= gate_d;
            err_q   <= err_d;
            case ({wr_acc, clr})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Timer is shared: VERIFY uses it for the password timeout, OPEN for the
    // gate hold time.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        slot_d  = slot_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !start_q) begin
                    state_d = SEARCH;
                    index_d = '0;
                end
            end
            SEARCH: begin
                if (hit) begin
                    state_d = VERIFY;
                    slot_d  = index_q;
                    timer_d = '0;
                end else if (index_q == IW'(SLOTS - 1)) begin
                    state_d = REJECT;
                end else begin
                    index_d = index_q + IW'(1);
                end
            end
            VERIFY: begin
                if (!bus.start) begin
                    state_d = IDLE;
                end else if (bus.pswd == PASSWORD) begin
                    state_d = OPEN;
                    timer_d = '0;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = REJECT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            OPEN: begin
                if (timer_q == TW'(OPEN_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gate_d = (state_d == OPEN);
        err_d  = (state_d == REJECT);
        clr    = (state_q == VERIFY) && (state_d == OPEN);
    end

    assign bus.gate  = gate_q;
    assign bus.err   = err_q;
    assign bus.slot  = slot_q;
    assign bus.full  = full;
    assign bus.count = count_q;

endmodule

// File: doc/park_exit.md
Name: park_exit

Overview:
- Exit-side controller for the car park. The entry gate registers each admitted vehicle number into this block's occupancy table.
- A departing vehicle presents its number plus the shared password. The block searches the table, verifies the password, frees the slot and opens the exit gate for a fixed time.
- Sits alongside the entry controller. Its entry_vld/entry_vn inputs are driven by the entry side's admit event.

Parameters:
- N, 4, vehicle-number and password width
- SLOTS, 16, table depth; power of two, at least 2
- PASSWORD, 4'b1010, exit password; must equal the entry-side value
- OPEN_CYC, 4, cycles the exit gate stays open
- TIMEOUT, 8, cycles allowed in VERIFY before rejecting

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- entry_vld  in  1  one-cycle pulse: store entry_vn in the table
- entry_vn  in  N  vehicle number being admitted
- start  in  1  exit request; the rising edge is the trigger
- vn  in  N  departing vehicle number; sampled in SEARCH
- pswd  in  N  password; sampled in VERIFY
- gate  out  1  exit gate open
- slot  out  log2(SLOTS)  index of the slot being freed; valid while gate=1
- err  out  1  one-cycle pulse: vehicle not found, or password timeout
- full  out  1  all slots occupied (combinational from the valid bits)
- count  out  log2(SLOTS)+1  number of occupied slots

Behaviour:
- Reset (async, rst_n=0):
  - all valid bits cleared, count=0, state=IDLE, index=0, timer=0
  - gate=0, slot=0, err=0, full=0
- Table write:
  - On entry_vld=1, entry_vn goes to the lowest-index free slot; its valid bit sets and count increments next edge.
  - If full=1, the write is dropped and count is unchanged.
  - If entry_vn is already valid in the table, the write is dropped (no duplicate entries).
  - A slot freed on a given edge is not reusable until the following cycle.
  - If a write and a free land on the same edge, count is unchanged.
- FSM states: IDLE, SEARCH, VERIFY, OPEN, REJECT.
- IDLE:
  - A start rising edge (start=1 now, registered start_d=0) moves to SEARCH next edge, with index=0.
  - A start held high does not retrigger.
- SEARCH:
  - One entry examined per cycle: valid[index] && table[index]==vn.
  - On a hit: go to VERIFY, latch slot=index, timer=0.
  - On a miss at index=SLOTS-1: go to REJECT. Otherwise index+1.
  - A match at index i reaches VERIFY i+1 cycles after entering SEARCH.
  - An entry written during SEARCH at an index already passed is not found.
- VERIFY:
  - If pswd==PASSWORD: go to OPEN. The valid bit of slot clears and count decrements on that same edge.
  - If start=0: abort to IDLE with no error and the table unchanged.
  - If timer reaches TIMEOUT-1 without a match: go to REJECT.
  - Password match takes priority over timeout in the same cycle; start=0 takes priority over both.
- OPEN:
  - gate=1 for exactly OPEN_CYC cycles, slot held steady, then IDLE.
  - start is ignored while in OPEN.
- REJECT:
  - err=1 for exactly one cycle, then IDLE. Table untouched.
- Outputs:
  - gate and err are registered, decoded from state.
  - full = all valid bits set.
  - count saturates at neither end; it is bounded by construction.
- Reset mid-operation: gate drops immediately (asynchronously) and the table is cleared.

Decomposition:
- park_pkg:
  - state enum (IDLE, SEARCH, VERIFY, OPEN, REJECT)
  - PASSWORD default
  - width localparams: index width = $clog2(SLOTS); count width = $clog2(SLOTS+1)
- Sub-module park_table:
  - storage plus valid bits
  - lowest-free-slot priority encoder, full flag and duplicate detect
  - indexed read port for the search, clear port for the free
- park_exit holds the FSM, the index/timer counters, start edge detection and count.

Test Plan:
- Reset, then entry_vld with entry_vn=8, 12, 3 -> count=3, full=0; slots 0,1,2 hold 8,12,3.
- Exit vn=3: start rises, pswd=1010 held -> VERIFY 3 cycles after SEARCH entry; gate=1 for 4 cycles with slot=2; count=2; slot 2 reusable on the next entry.
- Exit vn=5 (absent) -> 16 SEARCH cycles, then err pulses 1 cycle; gate stays 0; count unchanged.
- Exit vn=12 with pswd=1101 for 8 cycles -> err pulse; table unchanged. Repeat with start dropped mid-VERIFY -> IDLE, no err.
- Fill 16 slots, then a 17th entry_vld -> dropped, full=1, count=16. Duplicate entry_vn=8 after a free -> dropped.
- rst_n asserted low during OPEN -> gate=0 immediately; count=0, full=0; a subsequent exit search for 8 returns err.
